// File: rtl/router_model.sv
// Single-input, four-output registered router: din is steered to the port
// selected by addr when d_en is high; all other ports read zero.
module router_model #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  d_en,
  input  logic [1:0]            addr,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic [DATA_WIDTH-1:0] dout2,
  output logic [DATA_WIDTH-1:0] dout3,
  output logic [3:0]            dout_vld
);

  localparam int NUM_PORTS = 4;
  localparam int STAGES    = 1;

  typedef struct packed {
    logic                  en;
    logic [1:0]            addr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  req_t req;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] dout_q;

  assign req = '{en: d_en, addr: addr, data: din};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [STAGES:0]       vld_pipe;
    logic [DATA_WIDTH-1:0] data_q;

    // Short-circuit on en keeps an unknown addr from reaching the flops
    // while the router is idle.
    assign vld_pipe[0] = req.en && (req.addr == 2'(p));

    // Outputs never hold: a port not selected this cycle loads zero.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        vld_pipe[STAGES:1] <= '0;
        data_q             <= '0;
      end else begin
        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
        data_q             <= vld_pipe[0] ? req.data : '0;
      end
    end

    assign dout_q[p]   = data_q;
    assign dout_vld[p] = vld_pipe[STAGES];
  end

  assign dout0 = dout_q[0];
  assign dout1 = dout_q[1];
  assign dout2 = dout_q[2];
  assign dout3 = dout_q[3];

endmodule

// File: tb/tb_router_model.sv
// Scoreboard bench for router_model: every driven cycle pushes the expected
// {dout_vld, dout3..dout0} image; it is popped and compared one edge later.
module tb_router_model;
  localparam int DW = 32;
  localparam int VW = 4 + 4*DW;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] din;
  logic          d_en;
  logic [1:0]    addr;
  logic [DW-1:0] dout0, dout1, dout2, dout3;
  logic [3:0]    dout_vld;

  int total = 0;
  int passed = 0;
  logic [VW-1:0] sb[$];
  logic [VW-1:0] exp_v;

  router_model #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .resetn(resetn), .din(din), .d_en(d_en), .addr(addr),
    .dout0(dout0), .dout1(dout1), .dout2(dout2), .dout3(dout3),
    .dout_vld(dout_vld)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] model(input logic en, input logic [1:0] a,
                                          input logic [DW-1:0] d);
    logic [3:0]         v;
    logic [3:0][DW-1:0] o;
    v = '0;
    o = '0;
    if (en === 1'b1) begin
      v[a] = 1'b1;
      o[a] = d;
    end
    return {v, o};
  endfunction

  function automatic logic [VW-1:0] observed();
    return {dout_vld, dout3, dout2, dout1, dout0};
  endfunction

  // Apply inputs, record what the next edge must produce, then step past it.
  task automatic drive(input logic en, input logic [1:0] a, input logic [DW-1:0] d);
    d_en = en;
    addr = a;
    din  = d;
    sb.push_back(model(en, a, d));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    d_en   = 1'b1;
    addr   = 2'd0;
    din    = 32'hBEAD;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (observed() !== '0)
      $display("FAIL reset_hold got %h exp 0", observed());
    else passed++;
    @(negedge clk);
    resetn = 1'b1;
    d_en   = 1'b0;
    @(posedge clk);
    #1;
    // load a word, then assert reset mid-cycle and look before any edge
    drive(1'b1, 2'd2, 32'h1234_5678);
    exp_v = sb.pop_front();
    total++;
    if (observed() !== exp_v)
      $display("FAIL reset_preload got %h exp %h", observed(), exp_v);
    else passed++;
    #2 resetn = 1'b0;
    #1;
    total++;
    if (observed() !== '0)
      $display("FAIL reset_async got %h exp 0", observed());
    else passed++;
    @(negedge clk);
    resetn = 1'b1;
    d_en   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_enable();
    drive(1'b0, 2'd0, 32'hBEAD);
    exp_v = sb.pop_front();
    total++;
    if (observed() !== exp_v)
      $display("FAIL enable_off got %h exp %h", observed(), exp_v);
    else passed++;
    drive(1'b1, 2'd0, 32'hBEAD);
    exp_v = sb.pop_front();
    total++;
    if (observed() !== exp_v || dout0 !== 32'hBEAD || dout_vld !== 4'b0001)
      $display("FAIL enable_on got %h exp %h", observed(), exp_v);
    else passed++;
    // unknown addr while idle must not disturb anything
    drive(1'b0, 2'bxx, 32'hDEAD_BEEF);
    exp_v = sb.pop_front();
    total++;
    if (observed() !== exp_v)
      $display("FAIL enable_xaddr got %h exp %h", observed(), exp_v);
    else passed++;
  endtask

  task automatic test_sweep();
    logic [3:0] vexp;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 32'hBEAD);
      exp_v = sb.pop_front();
      vexp  = 4'b0001 << i;
      total++;
      if (observed() !== exp_v || dout_vld !== vexp)
        $display("FAIL sweep_a%0d got %h exp %h", i, observed(), exp_v);
      else passed++;
    end
  endtask

  task automatic test_data();
    logic [DW-1:0] pats[3];
    pats = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hA5A5_A5A5};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd3, pats[i]);
      exp_v = sb.pop_front();
      total++;
      if (observed() !== exp_v || dout3 !== pats[i] || (dout0 | dout1 | dout2) !== '0)
        $display("FAIL data_%0d got %h exp %h", i, observed(), exp_v);
      else passed++;
    end
  endtask

  task automatic test_drop();
    drive(1'b1, 2'd2, 32'hBEAD);
    exp_v = sb.pop_front();
    total++;
    if (observed() !== exp_v || dout2 !== 32'hBEAD)
      $display("FAIL drop_load got %h exp %h", observed(), exp_v);
    else passed++;
    drive(1'b0, 2'd2, 32'hBEAD);
    exp_v = sb.pop_front();
    total++;
    if (observed() !== exp_v || dout2 !== '0 || dout_vld !== 4'b0000)
      $display("FAIL drop_clear got %h exp %h", observed(), exp_v);
    else passed++;
  endtask

  task automatic test_midreset();
    drive(1'b1, 2'd1, 32'h1111_1111);
    exp_v = sb.pop_front();
    total++;
    if (observed() !== exp_v || dout1 !== 32'h1111_1111)
      $display("FAIL midrst_load got %h exp %h", observed(), exp_v);
    else passed++;
    d_en = 1'b1;
    addr = 2'd1;
    din  = 32'h2222_2222;
    #2 resetn = 1'b0;
    #1;
    total++;
    if (dout1 !== '0 || observed() !== '0)
      $display("FAIL midrst_async got %h exp 0", observed());
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (observed() !== '0)
      $display("FAIL midrst_hold got %h exp 0", observed());
    else passed++;
    @(negedge clk);
    resetn = 1'b1;
    drive(1'b1, 2'd1, 32'h3333_3333);
    exp_v = sb.pop_front();
    total++;
    if (observed() !== exp_v || dout1 !== 32'h3333_3333 || dout_vld !== 4'b0010)
      $display("FAIL midrst_resume got %h exp %h", observed(), exp_v);
    else passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), DW'($urandom));
      exp_v = sb.pop_front();
      total++;
      if (observed() !== exp_v)
        $display("FAIL b2b_%0d got %h exp %h", i, observed(), exp_v);
      else passed++;
      total++;
      if (!$onehot0(dout_vld))
        $display("FAIL b2b_onehot_%0d got %b exp one-hot-or-zero", i, dout_vld);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_enable();
    test_sweep();
    test_data();
    test_drop();
    test_midreset();
    test_back_to_back();
    total++;
    if (sb.size() != 0)
      $display("FAIL sb_drain got %0d exp 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
